// File: rtl/pc_gen.sv
// pc_gen: rv32i fetch program counter. It holds the fetch PC, offers it to
// instruction memory through a valid/ready handshake, and picks the next PC
// from trap, resolved redirect, a predicted call or return, or the
// sequential address. A small circular return-address stack (RAS) supplies
// the predicted return targets.
module pc_gen #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus_4,
    output logic                pc_valid,
    input  logic                fetch_ready,
    input  logic                trap_valid,
    input  logic [PC_WIDTH-1:0] trap_vector,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                call_valid,
    input  logic [PC_WIDTH-1:0] call_target,
    input  logic                ret_valid,
    output logic                misalign_err,
    output logic                ras_empty,
    output logic                ras_full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL_CNT = CW'(RAS_DEPTH);

    // Fetch-side state.
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                pc_valid_q;
    logic                misalign_q, misalign_d;

    // RAS state: ptr_q is the next free slot, so the top lives at ptr_q-1.
    // With a circular pointer, a push while full lands on the oldest entry.
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                empty_q, full_q;

    logic                push_en;
    logic [PW-1:0]       push_idx;
    logic [PW-1:0]       top_idx;
    logic                fire;

    assign pc_plus_4    = pc_q + PC_WIDTH'(4);
    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_q;
    assign ras_empty    = empty_q;
    assign ras_full     = full_q;

    assign fire    = pc_valid_q & fetch_ready;
    assign top_idx = ptr_q - PW'(1);

    // Next-PC selection and RAS push/pop decision, highest priority first.
    always_comb begin
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        push_en    = 1'b0;
        push_idx   = ptr_q;
        if (trap_valid) begin
            pc_d = trap_vector & ~PC_WIDTH'(3);
        end else if (redirect_valid) begin
            // A misaligned redirect is rejected: pc holds, only the error pulses.
            if (redirect_target[1:0] == 2'b00) begin
                pc_d = redirect_target;
            end else begin
                misalign_d = 1'b1;
            end
        end else if (fire) begin
            if (ret_valid && (cnt_q != '0)) begin
                pc_d = ras_q[top_idx];
                if (call_valid) begin
                    // Pop then push into the freed slot: pointer and count stay.
                    push_en  = 1'b1;
                    push_idx = top_idx;
                end else begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (call_valid) begin
                pc_d     = call_target;
                push_en  = 1'b1;
                push_idx = ptr_q;
                ptr_d    = ptr_q + PW'(1);
                if (cnt_q != RAS_FULL_CNT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                pc_d = pc_plus_4;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
            misalign_q <= misalign_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            empty_q    <= (cnt_d == '0);
            full_q     <= (cnt_d == RAS_FULL_CNT);
        end
    end

    // RAS storage; entries need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            ras_q[push_idx] <= pc_plus_4;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed steps from the test plan followed by a
// randomized run, all checked against a queue-based reference model.
module tb_pc_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_plus_4;
    logic        pc_valid;
    logic        fetch_ready;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call_valid;
    logic [31:0] call_target;
    logic        ret_valid;
    logic        misalign_err, ras_empty, ras_full;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_gen #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_plus_4(pc_plus_4), .pc_valid(pc_valid),
        .fetch_ready(fetch_ready), .trap_valid(trap_valid), .trap_vector(trap_vector),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call_valid(call_valid), .call_target(call_target), .ret_valid(ret_valid),
        .misalign_err(misalign_err), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the architectural
    // rules, then compare every output just after the edge.
    task automatic step(input logic r, input logic rdy,
                        input logic tv, input logic [31:0] tvec,
                        input logic rv, input logic [31:0] rt,
                        input logic cv, input logic [31:0] ct,
                        input logic retv);
        logic [31:0] nxt;
        logic        fire;
        rst = r; fetch_ready = rdy; trap_valid = tv; trap_vector = tvec;
        redirect_valid = rv; redirect_target = rt; call_valid = cv;
        call_target = ct; ret_valid = retv;
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_ras.delete();
        end else begin
            fire  = m_valid && rdy;
            nxt   = m_pc;
            m_mis = 1'b0;
            if (tv) begin
                nxt = {tvec[31:2], 2'b00};
            end else if (rv) begin
                if (rt % 4 == 0) nxt = rt;
                else m_mis = 1'b1;
            end else if (fire) begin
                if (retv && m_ras.size() > 0) begin
                    nxt = m_ras.pop_back();
                    if (cv) m_ras.push_back(m_pc + 32'd4);
                end else if (cv) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    nxt = ct;
                end else begin
                    nxt = m_pc + 32'd4;
                end
            end
            m_pc    = nxt;
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
        chk("ras_full", {31'b0, ras_full}, {31'b0, (m_ras.size() == DEPTH)});
        $display("step rst=%0b rdy=%0b trap=%0b redir=%0b call=%0b ret=%0b -> pc=%h valid=%0b mis=%0b empty=%0b full=%0b",
                 r, rdy, tv, rv, cv, retv, pc, pc_valid, misalign_err, ras_empty, ras_full);
    endtask

    // Shorthands for the common cases.
    task automatic do_rst();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic idle(input logic rdy);
        step(0, rdy, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic redir(input logic [31:0] t);
        step(0, 1, 0, 0, 1, t, 0, 0, 0);
    endtask
    task automatic call(input logic [31:0] t);
        step(0, 1, 0, 0, 0, 0, 1, t, 0);
    endtask
    task automatic ret();
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 0; trap_valid = 0; trap_vector = 0;
        redirect_valid = 0; redirect_target = 0; call_valid = 0;
        call_target = 0; ret_valid = 0;
        m_pc = 0; m_valid = 0; m_mis = 0;

        // Reset and sequential fetch: pc 0, 4, 8, 0xC, then 0x10.
        do_rst(); do_rst();
        for (int i = 0; i < 5; i++) idle(1);
        chk("seq_pc_0x10", pc, 32'h10);

        // Stall for four cycles at 0x10, then advance to 0x14.
        for (int i = 0; i < 4; i++) idle(0);
        chk("stall_hold", pc, 32'h10);
        idle(1);
        chk("stall_release", pc, 32'h14);

        // Priority: trap beats redirect and call; redirect alone follows.
        redir(32'h20);
        step(0, 1, 1, 32'h103, 1, 32'h80, 1, 32'h500, 0);
        chk("prio_trap", pc, 32'h100);
        chk("prio_ras_untouched", {31'b0, ras_empty}, 32'h1);
        redir(32'h80);
        chk("prio_redirect", pc, 32'h80);

        // Misaligned redirect: hold, one-cycle pulse; then back-to-back pulses.
        redir(32'h40);
        redir(32'h82);
        chk("mis_hold", pc, 32'h40);
        idle(0);
        chk("mis_pulse_end", {31'b0, misalign_err}, 32'h0);
        redir(32'h81); redir(32'h43); idle(0);

        // RAS call/return chain.
        do_rst(); idle(0);
        call(32'h100); call(32'h200); call(32'h300);
        ret(); chk("ret1", pc, 32'h204);
        ret(); chk("ret2", pc, 32'h104);
        ret(); chk("ret3", pc, 32'h4);
        ret(); chk("ret_empty_seq", pc, 32'h8);

        // RAS overflow: five calls into four entries, oldest overwritten.
        do_rst(); idle(0);
        call(32'h10); call(32'h20); call(32'h30); call(32'h40);
        chk("full_after_4", {31'b0, ras_full}, 32'h1);
        call(32'h50);
        ret(); chk("ovf_pop1", pc, 32'h44);
        ret(); chk("ovf_pop2", pc, 32'h34);
        ret(); chk("ovf_pop3", pc, 32'h24);
        ret(); chk("ovf_pop4", pc, 32'h14);
        ret(); chk("ovf_seq", pc, 32'h18);

        // Simultaneous call and return with a non-empty stack.
        call(32'h600);
        step(0, 1, 0, 0, 0, 0, 1, 32'h700, 1);
        chk("callret_top", pc, 32'h1C);
        ret(); chk("callret_pushed", pc, 32'h604);

        // Address wrap.
        redir(32'hFFFF_FFFC);
        idle(1);
        chk("wrap", pc, 32'h0);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t1, t2, t3;
            t1 = $urandom;
            t2 = $urandom & 32'hFFFF_FFF0;
            t3 = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t2 = t2 | ($urandom & 32'h3);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), t1,
                 ($urandom_range(0, 9) == 0), t2,
                 ($urandom_range(0, 2) == 0), t3,
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
